// File: rtl/othello_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | othello_pkg : constants shared by the board datapath and plotter |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package othello_pkg;

  localparam int CELL     = 12;
  localparam int PITCH    = 13;
  localparam int ORIGIN   = 9;
  localparam int RADIUS2X = 10;

  localparam logic [1:0] SEL_EMPTY = 2'd0;
  localparam logic [1:0] SEL_BOX   = 2'd1;
  localparam logic [1:0] SEL_P0    = 2'd2;
  localparam logic [1:0] SEL_P1    = 2'd3;

  localparam logic [2:0] BG_COLOUR     = 3'b010;
  localparam logic [2:0] CURSOR_COLOUR = 3'b110;
  localparam logic [2:0] P0_COLOUR     = 3'b111;
  localparam logic [2:0] P1_COLOUR     = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cell_renderer_disk_mask.sv
`default_nettype none
// +------------------------------------------------------------------+
// | disk_mask : combinational test of a cell pixel against the disk  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module disk_mask #(
  parameter int CELL     = othello_pkg::CELL,
  parameter int RADIUS2X = othello_pkg::RADIUS2X
) (
  input  logic [3:0] dx,
  input  logic [3:0] dy,
  output logic       inside_disk
);

  // Distances are in half-pixels so the centre of an even-sized cell is exact.
  localparam logic signed [5:0] OFFSET = 6'(CELL - 1);
  localparam logic [10:0]       LIMIT  = 11'(RADIUS2X * RADIUS2X);

  logic signed [5:0] ex, ey;
  logic [4:0]        ax, ay;
  logic [9:0]        sx, sy;
  logic [10:0]       dist2;

  always_comb begin
    ex          = $signed({1'b0, dx, 1'b0}) - OFFSET;
    ey          = $signed({1'b0, dy, 1'b0}) - OFFSET;
    ax          = ex[5] ? 5'(-ex) : ex[4:0];
    ay          = ey[5] ? 5'(-ey) : ey[4:0];
    sx          = 10'(ax) * 10'(ax);
    sy          = 10'(ay) * 10'(ay);
    dist2       = 11'(sx) + 11'(sy);
    inside_disk = (dist2 <= LIMIT);
  end

endmodule
`default_nettype wire

// File: rtl/cell_renderer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cell_renderer : streams one CELL x CELL sprite into vga_adapter  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module cell_renderer #(
  parameter int         CELL          = othello_pkg::CELL,
  parameter int         RADIUS2X      = othello_pkg::RADIUS2X,
  parameter logic [2:0] BG_COLOUR     = othello_pkg::BG_COLOUR,
  parameter logic [2:0] CURSOR_COLOUR = othello_pkg::CURSOR_COLOUR,
  parameter logic [2:0] P0_COLOUR     = othello_pkg::P0_COLOUR,
  parameter logic [2:0] P1_COLOUR     = othello_pkg::P1_COLOUR
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_base,
  input  logic [6:0] y_base,
  input  logic [1:0] select,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  import othello_pkg::*;

  localparam logic [3:0] LAST = 4'(CELL - 1);

  state_t     state_q, state_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d;
  logic [7:0] xb_q, xb_d, vga_x_q, vga_x_d;
  logic [6:0] yb_q, yb_d, vga_y_q, vga_y_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] colour_q, colour_d, pix_colour;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic       inside_disk, on_border;

  disk_mask #(
    .CELL     (CELL),
    .RADIUS2X (RADIUS2X)
  ) u_disk_mask (
    .dx          (dx_q),
    .dy          (dy_q),
    .inside_disk (inside_disk)
  );

  always_comb begin
    on_border = (dx_q == 4'd0) || (dx_q == LAST) || (dy_q == 4'd0) || (dy_q == LAST);
    case (sel_q)
      SEL_EMPTY: pix_colour = BG_COLOUR;
      SEL_BOX:   pix_colour = on_border   ? CURSOR_COLOUR : BG_COLOUR;
      SEL_P0:    pix_colour = inside_disk ? P0_COLOUR     : BG_COLOUR;
      default:   pix_colour = inside_disk ? P1_COLOUR     : BG_COLOUR;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    xb_d     = xb_q;
    yb_d     = yb_q;
    sel_d    = sel_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xb_d    = x_base;
          yb_d    = y_base;
          sel_d   = select;
          dx_d    = 4'd0;
          dy_d    = 4'd0;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        // Additions wrap naturally at the 8- and 7-bit screen widths.
        vga_x_d  = xb_q + {4'd0, dx_q};
        vga_y_d  = yb_q + {3'd0, dy_q};
        colour_d = pix_colour;
        plot_d   = 1'b1;
        if (dx_q == LAST) begin
          dx_d = 4'd0;
          if (dy_q == LAST) begin
            dy_d    = 4'd0;
            state_d = ST_DONE;
          end else begin
            dy_d = dy_q + 4'd1;
          end
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      dx_q     <= 4'd0;
      dy_q     <= 4'd0;
      xb_q     <= 8'd0;
      yb_q     <= 7'd0;
      sel_q    <= 2'd0;
      vga_x_q  <= 8'd0;
      vga_y_q  <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      xb_q     <= xb_d;
      yb_q     <= yb_d;
      sel_q    <= sel_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_renderer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cell_renderer : randomized self-checking bench for the plotter|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cell_renderer;

  localparam int CELL    = 12;
  localparam int NPIX    = CELL * CELL;
  localparam int R2X     = 10;
  localparam int TIMEOUT = 400;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_base = 8'd0;
  logic [6:0] y_base = 7'd0;
  logic [1:0] select = 2'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  int checks = 0;
  int errors = 0;

  int   cap_x[$], cap_y[$], cap_c[$], cap_k[$];
  int   done_k;
  logic busy_first, busy_last;

  cell_renderer dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .x_base     (x_base),
    .y_base     (y_base),
    .select     (select),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  function automatic bit in_disk(int dx, int dy);
    int ex = 2 * dx - (CELL - 1);
    int ey = 2 * dy - (CELL - 1);
    return (ex * ex + ey * ey) <= R2X * R2X;
  endfunction

  function automatic int model_colour(int sel, int dx, int dy);
    case (sel)
      0: return 2;
      1: return (dx == 0 || dy == 0 || dx == CELL - 1 || dy == CELL - 1) ? 6 : 2;
      2: return in_disk(dx, dy) ? 7 : 2;
      default: return in_disk(dx, dy) ? 0 : 2;
    endcase
  endfunction

  // Pulses start now, scrambles inputs during the draw, records every plotted pixel.
  // k counts clock edges after the accepting edge; returns at the done pulse.
  task automatic capture(input int xb, input int yb, input int sel, input int inj_cycle);
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_k.delete();
    done_k = -1; busy_first = 1'b0; busy_last = 1'b0;
    x_base = 8'(xb); y_base = 7'(yb); select = 2'(sel); start = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clock);
      start  = 1'b0;
      x_base = 8'($urandom);
      y_base = 7'($urandom);
      select = 2'($urandom);
      if (k == inj_cycle) begin
        start  = 1'b1;
        select = 2'd0;
      end
      if (vga_plot) begin
        cap_x.push_back(int'(vga_x));
        cap_y.push_back(int'(vga_y));
        cap_c.push_back(int'(vga_colour));
        cap_k.push_back(k);
      end
      if (k == 1)    busy_first = busy;
      if (k == NPIX) busy_last  = busy;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
               vga_x, vga_y, vga_colour, vga_plot, busy, done);
    end
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got plot=%b busy=%b done=%b want 0 0 0", vga_plot, busy, done);
    end
  endtask

  task automatic test_empty();
    int xb = 9, yb = 9, sel = 0;
    @(negedge clock);
    capture(xb, yb, sel, -1);
    checks++;
    if (cap_x.size() != NPIX) begin
      errors++; $display("FAIL empty_count got %0d want %0d", cap_x.size(), NPIX);
    end
    checks++;
    if (done_k != NPIX + 1) begin
      errors++; $display("FAIL empty_done_cycle got %0d want %0d", done_k, NPIX + 1);
    end
    checks++;
    if (cap_k.size() == NPIX && (cap_k[0] != 1 || cap_k[NPIX-1] != NPIX)) begin
      errors++; $display("FAIL empty_latency got first=%0d last=%0d want 1 %0d", cap_k[0], cap_k[NPIX-1], NPIX);
    end
    checks++;
    if (busy_first !== 1'b1 || busy_last !== 1'b1) begin
      errors++; $display("FAIL empty_busy got %b %b want 1 1", busy_first, busy_last);
    end
    for (int i = 0; i < NPIX && i < cap_x.size(); i++) begin
      int dx = i % CELL;
      int dy = i / CELL;
      checks++;
      if (cap_x[i] != xb + dx || cap_y[i] != yb + dy || cap_c[i] != model_colour(sel, dx, dy)) begin
        errors++;
        $display("FAIL empty_pixel%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 cap_x[i], cap_y[i], cap_c[i], xb + dx, yb + dy, model_colour(sel, dx, dy));
      end
    end
  endtask

  task automatic test_box();
    int border = 0, inner = 0;
    @(negedge clock);
    capture(100, 100, 1, -1);
    checks++;
    if (cap_x.size() != NPIX) begin
      errors++; $display("FAIL box_count got %0d want %0d", cap_x.size(), NPIX);
    end
    for (int i = 0; i < cap_c.size(); i++) begin
      if (cap_c[i] == 6) border++;
      if (cap_c[i] == 2) inner++;
      checks++;
      if (cap_c[i] != model_colour(1, i % CELL, i / CELL)) begin
        errors++; $display("FAIL box_pixel%0d colour got %0d want %0d", i, cap_c[i], model_colour(1, i % CELL, i / CELL));
      end
    end
    checks++;
    if (border != 44 || inner != 100) begin
      errors++; $display("FAIL box_split got border=%0d inner=%0d want 44 100", border, inner);
    end
    checks++;
    if (cap_x.size() == NPIX &&
        (cap_x[0] != 100 || cap_y[0] != 100 || cap_x[NPIX-1] != 111 || cap_y[NPIX-1] != 111)) begin
      errors++; $display("FAIL box_ends got (%0d,%0d)..(%0d,%0d) want (100,100)..(111,111)",
                         cap_x[0], cap_y[0], cap_x[NPIX-1], cap_y[NPIX-1]);
    end
  endtask

  task automatic test_disk();
    int got = 0, want = 0;
    @(negedge clock);
    capture(22, 9, 2, -1);
    for (int i = 0; i < NPIX; i++) if (in_disk(i % CELL, i / CELL)) want++;
    foreach (cap_c[i]) if (cap_c[i] == 7) got++;
    checks++;
    if (cap_c.size() != NPIX) begin
      errors++; $display("FAIL disk_count got %0d want %0d", cap_c.size(), NPIX);
    end else begin
      checks++;
      if (cap_c[5*CELL+5] != 7 || cap_c[0] != 2) begin
        errors++; $display("FAIL disk_probe got centre=%0d corner=%0d want 7 2", cap_c[5*CELL+5], cap_c[0]);
      end
    end
    checks++;
    if (got != want) begin
      errors++; $display("FAIL disk_area got %0d want %0d", got, want);
    end
  endtask

  task automatic test_ignored_start();
    int xb = 40, yb = 60, sel = 3;
    @(negedge clock);
    capture(xb, yb, sel, 30);
    checks++;
    if (cap_x.size() != NPIX || done_k != NPIX + 1) begin
      errors++; $display("FAIL ignored_start got count=%0d done=%0d want %0d %0d", cap_x.size(), done_k, NPIX, NPIX + 1);
    end
    for (int i = 0; i < NPIX && i < cap_x.size(); i++) begin
      int dx = i % CELL;
      int dy = i / CELL;
      checks++;
      if (cap_x[i] != xb + dx || cap_y[i] != yb + dy || cap_c[i] != model_colour(sel, dx, dy)) begin
        errors++;
        $display("FAIL ignored_pixel%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 cap_x[i], cap_y[i], cap_c[i], xb + dx, yb + dy, model_colour(sel, dx, dy));
      end
    end
  endtask

  // Each draw starts on the same edge that reveals the previous done, so no idle wait.
  task automatic test_random_back_to_back();
    for (int n = 0; n < 6; n++) begin
      int xb  = (n == 1) ? 250 : int'($urandom_range(255));
      int yb  = (n == 1) ? 124 : int'($urandom_range(127));
      int sel = int'($urandom_range(3));
      capture(xb, yb, sel, -1);
      checks++;
      if (cap_x.size() != NPIX || done_k != NPIX + 1 || (cap_k.size() > 0 && cap_k[0] != 1)) begin
        errors++;
        $display("FAIL b2b%0d_timing got count=%0d done=%0d first=%0d want %0d %0d 1", n,
                 cap_x.size(), done_k, (cap_k.size() > 0) ? cap_k[0] : -1, NPIX, NPIX + 1);
      end
      for (int i = 0; i < NPIX && i < cap_x.size(); i++) begin
        int dx = i % CELL;
        int dy = i / CELL;
        checks++;
        if (cap_x[i] != (xb + dx) % 256 || cap_y[i] != (yb + dy) % 128 ||
            cap_c[i] != model_colour(sel, dx, dy)) begin
          errors++;
          $display("FAIL b2b%0d_pixel%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", n, i,
                   cap_x[i], cap_y[i], cap_c[i], (xb + dx) % 256, (yb + dy) % 128, model_colour(sel, dx, dy));
        end
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int plots = 0, late_plots = 0, dones = 0;
    bit hit = 0;
    @(negedge clock);
    x_base = 8'd30; y_base = 7'd30; select = 2'($urandom); start = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (vga_plot) plots++;
      if (plots == 50) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL abort_reach_pixel50 got %0d plots want 50", plots);
    end
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got plot=%b busy=%b done=%b want 0 0 0", vga_plot, busy, done);
    end
    resetn = 1'b1;
    repeat (200) begin
      @(negedge clock);
      if (done) dones++;
      if (vga_plot) late_plots++;
    end
    checks++;
    if (dones != 0 || late_plots != 0) begin
      errors++; $display("FAIL abort_quiet got done=%0d plots=%0d want 0 0", dones, late_plots);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_box();
    test_disk();
    test_ignored_start();
    test_random_back_to_back();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
